// File: rtl/load_gate_pkg.sv
// Shared encodings for the load sequencer / clock-gate controller.
package load_gate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OPEN = 2'b01,
    LOAD = 2'b10
  } state_t;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned REQ_A   = 0;
  localparam int unsigned REQ_B   = 1;

  localparam logic SEL_R1 = 1'b0;
  localparam logic SEL_R2 = 1'b1;

endpackage

// File: rtl/load_gate_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered priority pointer.
module rr_arb2
  import load_gate_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic               ptr
);

  // Pointer only breaks ties; a lone request always wins.
  always_comb begin
    gnt_c = '0;
    if (req[REQ_A] && req[REQ_B]) begin
      if (ptr == 1'(REQ_B)) gnt_c[REQ_B] = 1'b1;
      else                  gnt_c[REQ_A] = 1'b1;
    end else if (req[REQ_A]) begin
      gnt_c[REQ_A] = 1'b1;
    end else if (req[REQ_B]) begin
      gnt_c[REQ_B] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= 1'(REQ_A);
    end else if (adv && (|gnt_c)) begin
      ptr <= gnt_c[REQ_A] ? 1'(REQ_B) : 1'(REQ_A);
    end
  end

endmodule

// File: rtl/load_gate_ctrl.sv
// Arbitrated two-register load sequencer; gate enable opens one cycle before the load strobe.
// Optional statistics counters are built when LOAD_GATE_STATS_EN is defined.
module load_gate_ctrl
  import load_gate_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_sel,
  input  logic [DW-1:0] a_data,
  output logic          a_gnt,
  input  logic          b_req,
  input  logic          b_sel,
  input  logic [DW-1:0] b_data,
  output logic          b_gnt,
  output logic          en1,
  output logic          en2,
  output logic          ld1,
  output logic          ld2,
  output logic [DW-1:0] d1,
  output logic [DW-1:0] d2,
  output logic          busy
`ifdef LOAD_GATE_STATS_EN
  ,
  output logic [CNT_W-1:0] load_cnt1,
  output logic [CNT_W-1:0] load_cnt2,
  output logic [CNT_W-1:0] idle_cnt
`endif
);

  state_t state, state_nxt;

  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] win_c;
  logic               ptr;
  logic               arb_adv_c;
  logic               win_sel_c;
  logic [DW-1:0]      win_data_c;

  logic               lat_sel;
  logic [DW-1:0]      lat_data;

  logic               tgt_sel_c;
  logic               a_gnt_nxt, b_gnt_nxt, en1_nxt, en2_nxt, ld1_nxt, ld2_nxt, busy_nxt;
  logic [DW-1:0]      d_nxt;

  assign req_vec[REQ_A] = a_req;
  assign req_vec[REQ_B] = b_req;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_vec),
    .adv   (arb_adv_c),
    .gnt_c (win_c),
    .ptr   (ptr)
  );

  assign win_sel_c  = win_c[REQ_B] ? b_sel  : a_sel;
  assign win_data_c = win_c[REQ_B] ? b_data : a_data;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    state_nxt = state;
    arb_adv_c = 1'b0;
    case (state)
      IDLE: begin
        if (|req_vec) begin
          arb_adv_c = 1'b1;
          state_nxt = OPEN;
        end
      end
      OPEN: state_nxt = LOAD;
      LOAD: begin
        if (|req_vec) begin
          arb_adv_c = 1'b1;
          state_nxt = OPEN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    tgt_sel_c = arb_adv_c ? win_sel_c : lat_sel;
    a_gnt_nxt = arb_adv_c && win_c[REQ_A];
    b_gnt_nxt = arb_adv_c && win_c[REQ_B];
    busy_nxt  = (state_nxt != IDLE);
    en1_nxt   = busy_nxt && (tgt_sel_c == SEL_R1);
    en2_nxt   = busy_nxt && (tgt_sel_c == SEL_R2);
    ld1_nxt   = (state_nxt == LOAD) && (lat_sel == SEL_R1);
    ld2_nxt   = (state_nxt == LOAD) && (lat_sel == SEL_R2);
    d_nxt     = (state_nxt == LOAD) ? lat_data : d1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_sel  <= SEL_R1;
      lat_data <= '0;
    end else if (arb_adv_c) begin
      lat_sel  <= win_sel_c;
      lat_data <= win_data_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_gnt <= 1'b0;
      b_gnt <= 1'b0;
      en1   <= 1'b0;
      en2   <= 1'b0;
      ld1   <= 1'b0;
      ld2   <= 1'b0;
      busy  <= 1'b0;
      d1    <= '0;
      d2    <= '0;
    end else begin
      a_gnt <= a_gnt_nxt;
      b_gnt <= b_gnt_nxt;
      en1   <= en1_nxt;
      en2   <= en2_nxt;
      ld1   <= ld1_nxt;
      ld2   <= ld2_nxt;
      busy  <= busy_nxt;
      d1    <= d_nxt;
      d2    <= d_nxt;
    end
  end

  // A contested arbitration must follow the priority pointer.
  always_ff @(posedge clk) begin
    if (rst_n && arb_adv_c && (&req_vec)) begin
      assert (win_c[ptr]);
    end
  end

`ifdef LOAD_GATE_STATS_EN
  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_cnt1 <= '0;
      load_cnt2 <= '0;
      idle_cnt  <= '0;
    end else begin
      if (ld1 && (load_cnt1 != '1)) load_cnt1 <= load_cnt1 + CNT_W'(1);
      if (ld2 && (load_cnt2 != '1)) load_cnt2 <= load_cnt2 + CNT_W'(1);
      if (!en1 && !en2 && (idle_cnt != '1)) idle_cnt <= idle_cnt + CNT_W'(1);
    end
  end
`else
  if (CNT_W == 0) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_load_gate_ctrl.sv
// Directed self-checking bench for load_gate_ctrl; stats checks build when LOAD_GATE_STATS_EN is defined.
module tb_load_gate_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned CNT_W = 16;

  logic          clk;
  logic          rst_n;
  logic          a_req, a_sel, b_req, b_sel;
  logic [DW-1:0] a_data, b_data;
  logic          a_gnt, b_gnt, en1, en2, ld1, ld2, busy;
  logic [DW-1:0] d1, d2;
`ifdef LOAD_GATE_STATS_EN
  logic [CNT_W-1:0] load_cnt1, load_cnt2, idle_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  load_gate_ctrl #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a_req  (a_req),
    .a_sel  (a_sel),
    .a_data (a_data),
    .a_gnt  (a_gnt),
    .b_req  (b_req),
    .b_sel  (b_sel),
    .b_data (b_data),
    .b_gnt  (b_gnt),
    .en1    (en1),
    .en2    (en2),
    .ld1    (ld1),
    .ld2    (ld2),
    .d1     (d1),
    .d2     (d2),
    .busy   (busy)
`ifdef LOAD_GATE_STATS_EN
    ,
    .load_cnt1 (load_cnt1),
    .load_cnt2 (load_cnt2),
    .idle_cnt  (idle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {a_gnt,b_gnt,en1,en2,ld1,ld2,busy,d1,d2}
  function automatic logic [22:0] outs();
    return {a_gnt, b_gnt, en1, en2, ld1, ld2, busy, d1, d2};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_req = 1'b0; b_req = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [22:0] exp;
    exp = '0;
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL reset_in got=%h want=%h", outs(), exp);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_checks++;
      if (outs() !== exp) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got=%h want=%h", c, outs(), exp);
      end
    end
`ifdef LOAD_GATE_STATS_EN
    n_checks++;
    if (idle_cnt !== CNT_W'(10) || load_cnt1 !== '0 || load_cnt2 !== '0) begin
      n_fail++;
      $display("FAIL reset_stats idle=%0d l1=%0d l2=%0d want 10/0/0", idle_cnt, load_cnt1, load_cnt2);
    end
`endif
  endtask

  task automatic test_single_a();
    logic [22:0] exp [3];
    exp[0] = {7'b1010001, 8'd0, 8'd0};
    exp[1] = {7'b0010101, 8'd5, 8'd5};
    exp[2] = {7'b0000000, 8'd5, 8'd5};
    a_req = 1'b1; a_sel = 1'b0; a_data = 8'd5;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 0) a_req = 1'b0;
      n_checks++;
      if (outs() !== exp[c]) begin
        n_fail++;
        $display("FAIL single_a cyc=%0d got=%h want=%h", c + 1, outs(), exp[c]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [22:0] exp [5];
    exp[0] = {7'b1010001, 8'd0,  8'd0};
    exp[1] = {7'b0010101, 8'd5,  8'd5};
    exp[2] = {7'b0101001, 8'd5,  8'd5};
    exp[3] = {7'b0001011, 8'd10, 8'd10};
    exp[4] = {7'b0000000, 8'd10, 8'd10};
    do_reset();
    a_req = 1'b1; a_sel = 1'b0; a_data = 8'd5;
    b_req = 1'b1; b_sel = 1'b1; b_data = 8'd10;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 0) a_req = 1'b0;
      if (c == 2) b_req = 1'b0;
      n_checks++;
      if (outs() !== exp[c]) begin
        n_fail++;
        $display("FAIL simultaneous cyc=%0d got=%h want=%h", c + 1, outs(), exp[c]);
      end
    end
  endtask

  task automatic test_alternate();
    logic [22:0] exp;
    logic [7:0]  last_d;
    logic        a_turn;
    int          n_ld1, n_ld2;
    last_d = 8'd0;
    n_ld1 = 0; n_ld2 = 0;
    do_reset();
    a_req = 1'b1; a_sel = 1'b0; a_data = 8'd1;
    b_req = 1'b1; b_sel = 1'b1; b_data = 8'd2;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 16) begin a_req = 1'b0; b_req = 1'b0; end
      if ((k % 2) == 1) begin
        a_turn = (((k - 1) / 2) % 2) == 0;
        exp = {a_turn ? 7'b1010001 : 7'b0101001, last_d, last_d};
      end else begin
        a_turn = (((k / 2) - 1) % 2) == 0;
        last_d = a_turn ? 8'd1 : 8'd2;
        exp = {a_turn ? 7'b0010101 : 7'b0001011, last_d, last_d};
      end
      if (ld1) n_ld1++;
      if (ld2) n_ld2++;
      n_checks++;
      if (outs() !== exp) begin
        n_fail++;
        $display("FAIL alternate cyc=%0d got=%h want=%h", k, outs(), exp);
      end
    end
    tick();
    n_checks++;
    if (n_ld1 != 4 || n_ld2 != 4 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL alternate_counts ld1=%0d ld2=%0d busy=%b want 4/4/0", n_ld1, n_ld2, busy);
    end
`ifdef LOAD_GATE_STATS_EN
    n_checks++;
    if (load_cnt1 !== CNT_W'(4) || load_cnt2 !== CNT_W'(4)) begin
      n_fail++;
      $display("FAIL alternate_stats l1=%0d l2=%0d want 4/4", load_cnt1, load_cnt2);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [22:0] exp [5];
    exp[0] = {7'b1001001, 8'd0, 8'd0};
    exp[1] = {7'b0001011, 8'd3, 8'd3};
    exp[2] = {7'b0101001, 8'd3, 8'd3};
    exp[3] = {7'b0001011, 8'd4, 8'd4};
    exp[4] = {7'b0000000, 8'd4, 8'd4};
    do_reset();
    a_req = 1'b1; a_sel = 1'b1; a_data = 8'd3;
    b_req = 1'b1; b_sel = 1'b1; b_data = 8'd4;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 0) a_req = 1'b0;
      if (c == 2) b_req = 1'b0;
      n_checks++;
      if (outs() !== exp[c]) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d got=%h want=%h", c + 1, outs(), exp[c]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [22:0] exp;
    do_reset();
    a_req = 1'b1; a_sel = 1'b0; a_data = 8'd7;
    tick();
    exp = {7'b1010001, 8'd0, 8'd0};
    n_checks++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_open got=%h want=%h", outs(), exp);
    end
    rst_n = 1'b0; a_req = 1'b0;
    tick();
    rst_n = 1'b1;
    exp = '0;
    n_checks++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_drop got=%h want=%h", outs(), exp);
    end
    tick();
    n_checks++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_idle got=%h want=%h", outs(), exp);
    end
    b_req = 1'b1; b_sel = 1'b1; b_data = 8'd9;
    tick();
    b_req = 1'b0;
    exp = {7'b0101001, 8'd0, 8'd0};
    n_checks++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_new_open got=%h want=%h", outs(), exp);
    end
    tick();
    exp = {7'b0001011, 8'd9, 8'd9};
    n_checks++;
    if (outs() !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_new_load got=%h want=%h", outs(), exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_req = 1'b0; a_sel = 1'b0; a_data = '0;
    b_req = 1'b0; b_sel = 1'b0; b_data = '0;
    test_reset();
    test_single_a();
    test_simultaneous();
    test_alternate();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
